// File: rtl/irq_ctrl_if.sv
// Device-register bus between the bridge and irq_ctrl.
// Same PrAddr/Wr_en/Data_in/Data_out shape as the timer so the bridge decode is shared.
interface irq_ctrl_if;
    logic [3:2]  PrAddr;
    logic        Wr_en;
    logic [31:0] Data_in;
    logic [31:0] Data_out;

    modport master (output PrAddr, Wr_en, Data_in, input Data_out);
    modport slave  (input PrAddr, Wr_en, Data_in, output Data_out);
endinterface

// File: rtl/irq_ctrl.sv
// Interrupt controller: pending latch, mask, level/edge mode and nested priority (ISR stack).
// Higher source index is higher priority; CP0 takes IntReq/IntId and acks with int_ack.
module irq_ctrl #(
    parameter int N_SRC = 6
) (
    input  logic             clk,
    input  logic             reset,
    irq_ctrl_if.slave        bus,
    input  logic [N_SRC-1:0] irq_in,
    input  logic             int_ack,
    output logic [N_SRC-1:0] HWInt,
    output logic             IntReq,
    output logic [2:0]       IntId
);

    logic [N_SRC-1:0] mask;
    logic [N_SRC-1:0] mode;
    logic [N_SRC-1:0] pending;
    logic [N_SRC-1:0] isr;
    logic [N_SRC-1:0] irq_q;
    logic [N_SRC-1:0] irq_q2;

    logic [N_SRC-1:0] wdata;
    logic             wr_mask;
    logic             wr_mode;
    logic             wr_pend;
    logic             wr_eoi;
    logic             ack_fire;
    logic [2:0]       isr_top;
    logic [N_SRC-1:0] eligible;
    logic [N_SRC-1:0] pending_n;
    logic [N_SRC-1:0] isr_n;
    logic             unused_data_bits;

    assign wdata    = bus.Data_in[N_SRC-1:0];
    assign wr_mask  = bus.Wr_en && (bus.PrAddr == 2'b00);
    assign wr_mode  = bus.Wr_en && (bus.PrAddr == 2'b01);
    assign wr_pend  = bus.Wr_en && (bus.PrAddr == 2'b10);
    assign wr_eoi   = bus.Wr_en && (bus.PrAddr == 2'b11);
    assign ack_fire = int_ack && IntReq;

    generate
        if (N_SRC < 32) begin : g_unused
            assign unused_data_bits = ^bus.Data_in[31:N_SRC];
        end else begin : g_nounused
            assign unused_data_bits = 1'b0;
        end
    endgenerate

    assign HWInt = pending & mask;

    // Only sources strictly above the in-service level may preempt.
    always_comb begin
        isr_top  = 3'd0;
        eligible = '0;
        IntId    = 3'd0;
        for (int i = 0; i < N_SRC; i++) begin
            if (isr[i]) isr_top = 3'(i);
        end
        for (int i = 0; i < N_SRC; i++) begin
            eligible[i] = HWInt[i] && ((isr == '0) || (3'(i) > isr_top));
        end
        for (int i = 0; i < N_SRC; i++) begin
            if (eligible[i]) IntId = 3'(i);
        end
    end

    assign IntReq = |eligible;

    always_comb begin
        pending_n = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (mode[i]) begin
                // A new edge beats a clear landing in the same cycle.
                pending_n[i] = (irq_q[i] && !irq_q2[i]) ||
                               (pending[i] && !((wr_pend && wdata[i]) ||
                                                (ack_fire && (IntId == 3'(i)))));
            end else begin
                pending_n[i] = irq_q[i];
            end
            if (wr_mode && (wdata[i] != mode[i])) pending_n[i] = 1'b0;
        end
    end

    // EOI retires the current level first, so a simultaneous ack nests cleanly.
    always_comb begin
        isr_n = isr;
        for (int i = 0; i < N_SRC; i++) begin
            if (wr_eoi && (isr != '0) && (isr_top == 3'(i))) isr_n[i] = 1'b0;
        end
        for (int i = 0; i < N_SRC; i++) begin
            if (ack_fire && (IntId == 3'(i))) isr_n[i] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mask    <= '0;
            mode    <= '0;
            pending <= '0;
            isr     <= '0;
            irq_q   <= '0;
            irq_q2  <= '0;
        end else begin
            irq_q   <= irq_in;
            irq_q2  <= irq_q;
            pending <= pending_n;
            isr     <= isr_n;
            if (wr_mask) mask <= wdata;
            if (wr_mode) mode <= wdata;
        end
    end

    always_comb begin
        case (bus.PrAddr)
            2'b00:   bus.Data_out = 32'(mask);
            2'b01:   bus.Data_out = 32'(mode);
            2'b10:   bus.Data_out = 32'(pending);
            default: bus.Data_out = {16'b0, 8'(isr), IntReq, 4'b0, IntId};
        endcase
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// Bench for irq_ctrl: expected observations are queued with each stimulus step
// and drained against the DUT after the clock edge that should produce them.
module tb_irq_ctrl;
    localparam int N = 6;

    localparam int K_HW  = 0;
    localparam int K_REQ = 1;
    localparam int K_ID  = 2;
    localparam int K_RD  = 3;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] irq_in;
    logic         int_ack;
    logic [N-1:0] HWInt;
    logic         IntReq;
    logic [2:0]   IntId;

    irq_ctrl_if bus ();

    irq_ctrl #(.N_SRC(N)) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .irq_in  (irq_in),
        .int_ack (int_ack),
        .HWInt   (HWInt),
        .IntReq  (IntReq),
        .IntId   (IntId)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        string       tag;
        int          kind;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_core(input string tag, input logic [31:0] hw, input logic req, input logic [2:0] id);
        sb.push_back('{{tag, ".hw"}, K_HW, hw});
        sb.push_back('{{tag, ".req"}, K_REQ, 32'(req)});
        sb.push_back('{{tag, ".id"}, K_ID, 32'(id)});
    endtask

    task automatic exp_req(input string tag, input logic req);
        sb.push_back('{{tag, ".req"}, K_REQ, 32'(req)});
    endtask

    task automatic exp_rd(input string tag, input int addr, input logic [31:0] val);
        sb.push_back('{tag, K_RD + addr, val});
    endtask

    task automatic drain();
        exp_t       e;
        logic [3:2] saved;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.kind)
                K_HW:  check(e.tag, 32'(HWInt), e.val);
                K_REQ: check(e.tag, 32'(IntReq), e.val);
                K_ID:  check(e.tag, 32'(IntId), e.val);
                default: begin
                    saved = bus.PrAddr;
                    bus.PrAddr = 2'(e.kind - K_RD);
                    #1;
                    check(e.tag, bus.Data_out, e.val);
                    bus.PrAddr = saved;
                end
            endcase
        end
    endtask

    task automatic wr(input int addr, input logic [31:0] data);
        bus.PrAddr  = 2'(addr);
        bus.Data_in = data;
        bus.Wr_en   = 1'b1;
        tick();
        bus.Wr_en   = 1'b0;
    endtask

    task automatic ack();
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset       = 1'b1;
        irq_in      = '0;
        int_ack     = 1'b0;
        bus.PrAddr  = 2'b00;
        bus.Wr_en   = 1'b0;
        bus.Data_in = '0;
        tick();
        tick();
        reset = 1'b0;
        exp_core("rst", 0, 0, 0);
        exp_rd("rst.mask", 0, 0);
        exp_rd("rst.mode", 1, 0);
        exp_rd("rst.pend", 2, 0);
        exp_rd("rst.stat", 3, 0);
        drain();

        // level source 0, two-cycle latency in both directions
        wr(0, 32'h01);
        irq_in = 6'h01;
        tick();
        exp_core("lvl.lat1", 0, 0, 0);
        drain();
        tick();
        exp_core("lvl.lat2", 1, 1, 0);
        drain();
        irq_in = 6'h00;
        tick();
        exp_req("lvl.hold", 1);
        drain();
        tick();
        exp_core("lvl.drop", 0, 0, 0);
        drain();

        // edge source 2: held after one-cycle pulse, W1C, set beats clear
        wr(1, 32'h04);
        wr(0, 32'h04);
        irq_in = 6'h04;
        tick();
        irq_in = 6'h00;
        tick();
        exp_rd("edge.pend", 2, 32'h04);
        exp_core("edge.core", 32'h04, 1, 2);
        drain();
        tick();
        tick();
        exp_rd("edge.held", 2, 32'h04);
        drain();
        wr(2, 32'hFFFF_FF04);
        exp_rd("edge.w1c", 2, 0);
        exp_req("edge.w1c", 0);
        drain();
        irq_in = 6'h04;
        tick();
        irq_in = 6'h00;
        wr(2, 32'h04);
        exp_rd("edge.setwins", 2, 32'h04);
        drain();
        wr(2, 32'h04);
        exp_rd("edge.w1c2", 2, 0);
        drain();

        // nesting with level sources 1, 0, 4
        wr(1, 32'h00);
        wr(0, 32'h3F);
        irq_in = 6'h02;
        tick();
        tick();
        exp_core("nest.src1", 32'h02, 1, 1);
        drain();
        ack();
        exp_rd("nest.ack1", 3, 32'h0200);
        exp_req("nest.ack1", 0);
        drain();
        irq_in = 6'h03;
        tick();
        tick();
        exp_core("nest.src0", 32'h03, 0, 0);
        drain();
        irq_in = 6'h13;
        tick();
        tick();
        exp_core("nest.src4", 32'h13, 1, 4);
        drain();
        ack();
        exp_rd("nest.ack4", 3, 32'h1200);
        drain();
        wr(3, 32'h0);
        exp_rd("nest.eoi1", 3, 32'h0284);
        drain();
        wr(3, 32'h0);
        exp_rd("nest.eoi2", 3, 32'h0084);
        exp_core("nest.eoi2", 32'h13, 1, 4);
        drain();
        irq_in = 6'h00;
        tick();
        tick();
        exp_core("nest.idle", 0, 0, 0);
        drain();

        // ack without request and EOI with empty ISR are no-ops
        ack();
        exp_rd("noop.ack", 3, 0);
        drain();
        wr(3, 32'h0);
        exp_rd("noop.eoi", 3, 0);
        exp_rd("noop.pend", 2, 0);
        drain();

        // edge source 3 acked: pending cleared, ISR bit 3 set
        wr(1, 32'h08);
        wr(0, 32'h08);
        irq_in = 6'h08;
        tick();
        irq_in = 6'h00;
        tick();
        exp_core("src3.req", 32'h08, 1, 3);
        drain();
        ack();
        exp_rd("src3.pend", 2, 0);
        exp_rd("src3.stat", 3, 32'h0800);
        drain();
        wr(3, 32'h0);
        exp_rd("src3.eoi", 3, 0);
        drain();

        // mode change on bit 5 drops its pending bit
        irq_in = 6'h20;
        tick();
        tick();
        exp_rd("mchg.pre", 2, 32'h20);
        drain();
        wr(1, 32'h28);
        exp_rd("mchg.post", 2, 0);
        drain();
        irq_in = 6'h00;

        // build ISR=0x3 then reset with a write and ack in the same cycle
        wr(1, 32'h00);
        wr(0, 32'h3F);
        irq_in = 6'h01;
        tick();
        tick();
        ack();
        exp_rd("pre.isr1", 3, 32'h0100);
        drain();
        irq_in = 6'h03;
        tick();
        tick();
        exp_core("pre.src1", 32'h03, 1, 1);
        drain();
        ack();
        exp_rd("pre.isr3", 3, 32'h0300);
        exp_rd("pre.pend", 2, 32'h03);
        drain();
        reset       = 1'b1;
        bus.PrAddr  = 2'b01;
        bus.Data_in = 32'h3F;
        bus.Wr_en   = 1'b1;
        int_ack     = 1'b1;
        tick();
        reset     = 1'b0;
        bus.Wr_en = 1'b0;
        int_ack   = 1'b0;
        exp_core("midrst", 0, 0, 0);
        exp_rd("midrst.mask", 0, 0);
        exp_rd("midrst.mode", 1, 0);
        exp_rd("midrst.pend", 2, 0);
        exp_rd("midrst.stat", 3, 0);
        drain();
        irq_in = 6'h00;
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
